stream_merger: RTL and testbench

- Merges two AXI-Stream sources into one egress stream at packet granularity.
- Counterpart to the ingress splitter: that block separates protocol-processor requests from normal traffic; this block recombines protocol-processor responses (s00) with FIFO/bypass traffic (s01) toward the MAC/host path.
- Packets are never interleaved. Full tready backpressure on both inputs; registered output.

---
 rtl/stream_merger_pkg.sv | 20 ++
 rtl/stream_merger_axis_out_reg.sv | 50 +++++
 rtl/stream_merger.sv | 141 ++++++++++++++
 tb/tb_stream_merger.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_merger_pkg.sv
// stream_pkg: constants and types shared by the stream merger and the
// ingress splitter.
//   DATA_W / KEEP_W / USER_W : default AXI-Stream widths of the datapath
//   merge_state_e            : merger arbitration FSM states
//   PROT_PROC_REQUEST        : tuser tag that marks protocol-processor traffic
package stream_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int USER_W = 137;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } merge_state_e;

  localparam logic [7:0] PROT_PROC_REQUEST = 8'hA5;

endpackage

// File: rtl/stream_merger_axis_out_reg.sv
// axis_out_reg: registered AXI-Stream output stage.
//   CLK, RST        : clock, synchronous active-low reset (clears all outputs)
//   in_t*           : beat to be loaded
//   in_load         : load the beat this cycle (only legal while in_ready)
//   in_ready        : register is empty or is being drained this cycle
//   m_axis_*        : registered stream towards the consumer
// An unloaded register drops tvalid on a consumer handshake but keeps the
// payload, so the outputs never change while tvalid && !tready.
module axis_out_reg #(
  parameter int DATA_W = stream_pkg::DATA_W,
  parameter int KEEP_W = stream_pkg::KEEP_W,
  parameter int USER_W = stream_pkg::USER_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic [USER_W-1:0] in_tuser,
  input  logic              in_tlast,
  input  logic              in_load,
  output logic              in_ready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  assign in_ready = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (in_load) begin
      m_axis_tdata  <= in_tdata;
      m_axis_tkeep  <= in_tkeep;
      m_axis_tuser  <= in_tuser;
      m_axis_tlast  <= in_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_merger.sv
// stream_merger: packet-granular merge of two AXI-Stream sources.
//   s00_axis_* : protocol-processor responses
//   s01_axis_* : FIFO / bypass traffic
//   m_axis_*   : merged, registered egress stream
//   CLK, RST   : clock, synchronous active-low reset
// Packets are never interleaved. Arbitration happens in IDLE and is
// registered, costing one bubble cycle per packet.
// Build option MERGE_RR_EN: round-robin between the sources when both are
// valid in IDLE; otherwise s00 has fixed priority over s01.
module stream_merger #(
  parameter int DATA_W = stream_pkg::DATA_W,
  parameter int KEEP_W = stream_pkg::KEEP_W,
  parameter int USER_W = stream_pkg::USER_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] s00_axis_tdata,
  input  logic [KEEP_W-1:0] s00_axis_tkeep,
  input  logic [USER_W-1:0] s00_axis_tuser,
  input  logic              s00_axis_tlast,
  input  logic              s00_axis_tvalid,
  output logic              s00_axis_tready,
  input  logic [DATA_W-1:0] s01_axis_tdata,
  input  logic [KEEP_W-1:0] s01_axis_tkeep,
  input  logic [USER_W-1:0] s01_axis_tuser,
  input  logic              s01_axis_tlast,
  input  logic              s01_axis_tvalid,
  output logic              s01_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  import stream_pkg::*;

  merge_state_e      state, state_nxt;
  logic              last_grant, last_grant_nxt;  // 0: s00 served last, 1: s01
  logic              out_ready;
  logic              load;
  logic [DATA_W-1:0] sel_tdata;
  logic [KEEP_W-1:0] sel_tkeep;
  logic [USER_W-1:0] sel_tuser;
  logic              sel_tlast;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // tready is also gated by RST so a source never sees a handshake on the
  // edge that resets the merger.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    load            = 1'b0;
    case (state)
      IDLE: begin
`ifdef MERGE_RR_EN
        if (s00_axis_tvalid && s01_axis_tvalid)
          state_nxt = last_grant ? PASS0 : PASS1;
        else if (s00_axis_tvalid)
          state_nxt = PASS0;
        else if (s01_axis_tvalid)
          state_nxt = PASS1;
`else
        if (s00_axis_tvalid)
          state_nxt = PASS0;
        else if (s01_axis_tvalid)
          state_nxt = PASS1;
`endif
      end
      PASS0: begin
        s00_axis_tready = RST && out_ready;
        if (s00_axis_tvalid && s00_axis_tready) begin
          load = 1'b1;
          if (s00_axis_tlast) begin
            state_nxt      = IDLE;
            last_grant_nxt = 1'b0;
          end
        end
      end
      PASS1: begin
        s01_axis_tready = RST && out_ready;
        if (s01_axis_tvalid && s01_axis_tready) begin
          load = 1'b1;
          if (s01_axis_tlast) begin
            state_nxt      = IDLE;
            last_grant_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (state == PASS1) begin
      sel_tdata = s01_axis_tdata;
      sel_tkeep = s01_axis_tkeep;
      sel_tuser = s01_axis_tuser;
      sel_tlast = s01_axis_tlast;
    end else begin
      sel_tdata = s00_axis_tdata;
      sel_tkeep = s00_axis_tkeep;
      sel_tuser = s00_axis_tuser;
      sel_tlast = s00_axis_tlast;
    end
  end

  axis_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W)
  ) u_out (
    .CLK           (CLK),
    .RST           (RST),
    .in_tdata      (sel_tdata),
    .in_tkeep      (sel_tkeep),
    .in_tuser      (sel_tuser),
    .in_tlast      (sel_tlast),
    .in_load       (load),
    .in_ready      (out_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_stream_merger.sv
module tb_stream_merger;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 137;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] s00_axis_tdata = '0;
  logic [KW-1:0] s00_axis_tkeep = '0;
  logic [UW-1:0] s00_axis_tuser = '0;
  logic          s00_axis_tlast = 1'b0;
  logic          s00_axis_tvalid = 1'b0;
  logic          s00_axis_tready;
  logic [DW-1:0] s01_axis_tdata = '0;
  logic [KW-1:0] s01_axis_tkeep = '0;
  logic [UW-1:0] s01_axis_tuser = '0;
  logic          s01_axis_tlast = 1'b0;
  logic          s01_axis_tvalid = 1'b0;
  logic          s01_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;

  always #5 CLK = ~CLK;

  stream_merger #(
    .DATA_W (DW),
    .KEEP_W (KW),
    .USER_W (UW)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tkeep  (s00_axis_tkeep),
    .s00_axis_tuser  (s00_axis_tuser),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tkeep  (s01_axis_tkeep),
    .s01_axis_tuser  (s01_axis_tuser),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tready (s01_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-source packet queues, and one FIFO of beats in the
  // order the merger accepted them; egress must reproduce that FIFO exactly.
  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_q[$];
  int    out_src[$];
  int    out_cyc[$];
  logic [31:0] out_tag[$];
  int    ord_exp[$];

  bit    hold0 = 0, hold1 = 0;
  bit    gaps = 0;
  int    tr_mode = 0;
  int    pat_idx = 0;
  bit    pat [4];
  int    cyc = 0;
  int    acc0 = 0;
  bit    in_pkt = 0;
  bit    chk_s00_off = 0;
  bit    stall_prev = 0;
  logic [1023:0] prev_bus = '0;
  int    lg_model = 1;

  task automatic check(string tag, logic [1023:0] obs, logic [1023:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [UW-1:0] rnd_user();
    logic [159:0] u;
    for (int i = 0; i < 5; i++) u[i*32 +: 32] = $urandom();
    return u[UW-1:0];
  endfunction

  // Tag in data[31:0]: source [31:24], packet id [23:16], beat [15:0].
  task automatic add_pkt(int src, int id, int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data        = rnd_data();
      b.data[31:0]  = {8'(src), 8'(id), 16'(i)};
      b.keep        = {$urandom(), $urandom()};
      b.user        = rnd_user();
      b.last        = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // Packet-level arbitration rule when both sources wait in IDLE.
  function automatic int pick(int lg);
`ifdef MERGE_RR_EN
    return (lg == 1) ? 0 : 1;
`else
    return 0 * lg;
`endif
  endfunction

  task automatic build_order(int n0, int n1);
    int s;
    ord_exp.delete();
    while (n0 > 0 || n1 > 0) begin
      if (n0 > 0 && n1 > 0) s = pick(lg_model);
      else if (n0 > 0)      s = 0;
      else                  s = 1;
      ord_exp.push_back(s);
      lg_model = s;
      if (s == 0) n0--; else n1--;
    end
  endtask

  task automatic drive();
    if (q0.size() > 0 && (hold0 || !gaps || $urandom_range(0, 2) != 0)) begin
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = q0[0].data;
      s00_axis_tkeep  = q0[0].keep;
      s00_axis_tuser  = q0[0].user;
      s00_axis_tlast  = q0[0].last;
      hold0 = 1;
    end else begin
      s00_axis_tvalid = 1'b0;
      hold0 = 0;
    end
    if (q1.size() > 0 && (hold1 || !gaps || $urandom_range(0, 2) != 0)) begin
      s01_axis_tvalid = 1'b1;
      s01_axis_tdata  = q1[0].data;
      s01_axis_tkeep  = q1[0].keep;
      s01_axis_tuser  = q1[0].user;
      s01_axis_tlast  = q1[0].last;
      hold1 = 1;
    end else begin
      s01_axis_tvalid = 1'b0;
      hold1 = 0;
    end
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: begin
        m_axis_tready = pat[pat_idx % 4];
        pat_idx++;
      end
    endcase
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, then advance.
  task automatic cycle();
    beat_t e;
    logic [1023:0] bus;
    drive();
    #1;
    bus = '0;
    bus[714:0] = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
    check("tready_exclusive", 1024'(s00_axis_tready && s01_axis_tready), 0);
    if (chk_s00_off) check("s00_tready_idle", 1024'(s00_axis_tready), 0);
    if (stall_prev) check("stall_hold", bus, prev_bus);
    if (s00_axis_tvalid && s00_axis_tready) begin
      exp_q.push_back(q0.pop_front());
      hold0 = 0;
      acc0++;
    end
    if (s01_axis_tvalid && s01_axis_tready) begin
      exp_q.push_back(q1.pop_front());
      hold1 = 0;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1024'(m_axis_tdata[31:0]), 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 1024'(m_axis_tdata), 1024'(e.data));
        check("out_keep", 1024'(m_axis_tkeep), 1024'(e.keep));
        check("out_user", 1024'(m_axis_tuser), 1024'(e.user));
        check("out_last", 1024'(m_axis_tlast), 1024'(e.last));
        if (!in_pkt) out_src.push_back(int'(e.data[31:24]));
        in_pkt = !e.last;
      end
      out_cyc.push_back(cyc);
      out_tag.push_back(m_axis_tdata[31:0]);
    end
    stall_prev = m_axis_tvalid && !m_axis_tready && RST;
    prev_bus   = bus;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic drain(int budget, string tag);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || m_axis_tvalid) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 1024'(q0.size() + q1.size() + exp_q.size() + int'(m_axis_tvalid)), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int start;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

    // Reset held with both sources valid.
    RST = 1'b0;
    s00_axis_tvalid = 1'b1;
    s01_axis_tvalid = 1'b1;
    s00_axis_tdata  = rnd_data();
    s01_axis_tdata  = rnd_data();
    m_axis_tready   = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_m_tvalid", 1024'(m_axis_tvalid), 0);
      check("rst_m_tdata",  1024'(m_axis_tdata), 0);
      check("rst_m_tkeep",  1024'(m_axis_tkeep), 0);
      check("rst_m_tuser",  1024'(m_axis_tuser), 0);
      check("rst_m_tlast",  1024'(m_axis_tlast), 0);
      check("rst_s00_tready", 1024'(s00_axis_tready), 0);
      check("rst_s01_tready", 1024'(s01_axis_tready), 0);
      @(negedge CLK);
    end
    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
    RST = 1'b1;
    lg_model = 1;
    @(negedge CLK);

    // Single source: 4-beat s01 packet, first output two cycles after tvalid.
    add_pkt(1, 1, 4);
    out_cyc.delete();
    chk_s00_off = 1;
    start = cyc;
    drain(50, "single");
    chk_s00_off = 0;
    check("single_nbeats", 1024'(out_cyc.size()), 4);
    for (int i = 0; i < out_cyc.size() && i < 4; i++)
      check("single_cycle", 1024'(out_cyc[i]), 1024'(start + 2 + i));
    lg_model = 1;

    // Contention: two 3-beat packets presented together.
    add_pkt(0, 2, 3);
    add_pkt(1, 3, 3);
    build_order(1, 1);
    out_src.delete();
    out_cyc.delete();
    start = cyc;
    drain(50, "contend");
    check("contend_npkts", 1024'(out_src.size()), 2);
    for (int i = 0; i < out_src.size() && i < 2; i++)
      check("contend_order", 1024'(out_src[i]), 1024'(ord_exp[i]));
    check("contend_nbeats", 1024'(out_cyc.size()), 6);
    for (int i = 0; i < out_cyc.size() && i < 6; i++)
      check("contend_cycle", 1024'(out_cyc[i]), 1024'(start + 2 + i + (i >= 3 ? 1 : 0)));

    // Four back-to-back packets per source.
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 4 + p, 1 + p);
      add_pkt(1, 8 + p, 2);
    end
    build_order(4, 4);
    out_src.delete();
    drain(200, "multi");
    check("multi_npkts", 1024'(out_src.size()), 8);
    for (int i = 0; i < out_src.size() && i < 8; i++)
      check("multi_order", 1024'(out_src[i]), 1024'(ord_exp[i]));

    // Backpressure: tready pattern 1,0,0,1 over a 5-beat packet with data 1..5.
    begin
      beat_t b;
      for (int i = 0; i < 5; i++) begin
        b.data = '0;
        b.data[7:0] = 8'(i + 1);
        b.keep = '1;
        b.user = UW'(i);
        b.last = (i == 4);
        q0.push_back(b);
      end
    end
    tr_mode = 2;
    pat_idx = 0;
    out_tag.delete();
    drain(100, "bp");
    tr_mode = 0;
    check("bp_nbeats", 1024'(out_tag.size()), 5);
    for (int i = 0; i < out_tag.size() && i < 5; i++)
      check("bp_data", 1024'(out_tag[i]), 1024'(i + 1));

    // Random soak: source gaps, random downstream ready, lengths 1..6.
    gaps = 1;
    tr_mode = 1;
    for (int p = 0; p < 8; p++) begin
      add_pkt(0, 20 + p, $urandom_range(1, 6));
      add_pkt(1, 40 + p, $urandom_range(1, 6));
    end
    drain(3000, "soak");
    gaps = 0;
    tr_mode = 0;

    // Reset after two beats of a 4-beat packet.
    add_pkt(0, 60, 4);
    acc0 = 0;
    begin
      int n = 0;
      while (acc0 < 2 && n < 20) begin
        cycle();
        n++;
      end
      check("midrst_accepts", 1024'(acc0), 2);
    end
    RST = 1'b0;
    cycle();
    RST = 1'b1;
    q0.delete();
    hold0 = 0;
    in_pkt = 0;
    lg_model = 1;
    s00_axis_tvalid = 1'b0;
    #1;
    check("midrst_m_tvalid", 1024'(m_axis_tvalid), 0);
    check("midrst_s00_tready", 1024'(s00_axis_tready), 0);
    check("midrst_s01_tready", 1024'(s01_axis_tready), 0);
    check("midrst_pending", 1024'(exp_q.size()), 0);

    // A fresh packet after the truncated one.
    add_pkt(1, 61, 3);
    out_src.delete();
    out_tag.delete();
    drain(50, "fresh");
    check("fresh_nbeats", 1024'(out_tag.size()), 3);
    check("fresh_npkts", 1024'(out_src.size()), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
